forwarding_ctrl: RTL and testbench

- Generates the 2-bit select codes for the EX-stage operand-A and operand-B three-input forwarding muxes.
- Code meanings: 00 = register-file value, 01 = EX/MEM result, 10 = MEM/WB result. Code 11 is reserved; the mux outputs zero for it.
- Keeps its own shadow pipeline of destination-register, register-write and memory-read control through ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards and asserts a stall to the fetch/decode stages.

---
 rtl/forwarding_if.sv | 21 ++
 rtl/forwarding_ctrl.sv | 65 ++++++
 tb/tb_forwarding_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/forwarding_if.sv
// forwarding_if: decode-side request and forwarding/stall response bundle
interface forwarding_if #(parameter int REG_AW = 5);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              flush;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              stall;
    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, flush,
        input  fwd_a_sel, fwd_b_sel, stall
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, flush,
        output fwd_a_sel, fwd_b_sel, stall
    );
endinterface

// File: rtl/forwarding_ctrl.sv
// forwarding_ctrl: EX operand forwarding selects and load-use stall; FWD_PERF_EN adds stall/forward counters
module forwarding_ctrl #(
    parameter int REG_AW     = 5,
    parameter int NREGS_ZERO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    forwarding_if.slave bus
`ifdef FWD_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] fwd_cnt
`endif
);
    localparam logic [REG_AW-1:0] ZERO = REG_AW'(NREGS_ZERO);
    logic [REG_AW-1:0] idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
    logic              idex_regwrite, idex_memread, exmem_regwrite, memwb_regwrite;
    logic              bubble;
    assign bubble = bus.stall | bus.flush | ~bus.id_valid;
    assign bus.stall = bus.id_valid & idex_memread & (idex_rd != ZERO) &
                       ((idex_rd == bus.id_rs1) | (idex_rd == bus.id_rs2));
    // Youngest producer wins: EX/MEM is checked before MEM/WB
    always_comb begin
        bus.fwd_a_sel = (exmem_regwrite && exmem_rd != ZERO && exmem_rd == idex_rs1) ? 2'b01 :
                        (memwb_regwrite && memwb_rd != ZERO && memwb_rd == idex_rs1) ? 2'b10 : 2'b00;
        bus.fwd_b_sel = (exmem_regwrite && exmem_rd != ZERO && exmem_rd == idex_rs2) ? 2'b01 :
                        (memwb_regwrite && memwb_rd != ZERO && memwb_rd == idex_rs2) ? 2'b10 : 2'b00;
    end
    // Shadow pipeline: ID/EX takes a bubble on stall/flush/invalid, later stages always shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_rs1       <= '0;
            idex_rs2       <= '0;
            idex_rd        <= '0;
            idex_regwrite  <= 1'b0;
            idex_memread   <= 1'b0;
            exmem_rd       <= '0;
            exmem_regwrite <= 1'b0;
            memwb_rd       <= '0;
            memwb_regwrite <= 1'b0;
        end else begin
            idex_rs1       <= bubble ? '0 : bus.id_rs1;
            idex_rs2       <= bubble ? '0 : bus.id_rs2;
            idex_rd        <= bubble ? '0 : bus.id_rd;
            idex_regwrite  <= bubble ? 1'b0 : bus.id_regwrite;
            idex_memread   <= bubble ? 1'b0 : bus.id_memread;
            exmem_rd       <= idex_rd;
            exmem_regwrite <= idex_regwrite;
            memwb_rd       <= exmem_rd;
            memwb_regwrite <= exmem_regwrite;
        end
    end
`ifdef FWD_PERF_EN
    // Event counters; a cycle forwarding on both operands counts once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            stall_cnt <= stall_cnt + 32'(bus.stall);
            fwd_cnt   <= fwd_cnt + 32'((bus.fwd_a_sel != 2'b00) || (bus.fwd_b_sel != 2'b00));
        end
    end
`endif
endmodule

// File: tb/tb_forwarding_ctrl.sv
// tb_forwarding_ctrl: directed checks of forwarding selects, load-use stall, flush, x0 and reset (FWD_PERF_EN adds counter checks)
module tb_forwarding_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    forwarding_if #(.REG_AW(5)) bus ();
`ifdef FWD_PERF_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif
    forwarding_ctrl #(.REG_AW(5), .NREGS_ZERO(0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef FWD_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .fwd_cnt(fwd_cnt)
`endif
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
        bus.id_valid    = v;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        bus.flush       = fl;
        #1;
    endtask

    task automatic edge_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (n) edge_clk();
    endtask

    task automatic scen_ex_mem();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        edge_clk();
        drive(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0);
        edge_clk();
        chk("exmem_a", 32'(bus.fwd_a_sel), 32'd1);
        chk("exmem_b", 32'(bus.fwd_b_sel), 32'd0);
        idle(3);
    endtask

    task automatic scen_load_use();
        drive(1'b1, 5'd2, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        edge_clk();
        drive(1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("lu_stall_on", 32'(bus.stall), 32'd1);
        edge_clk();
        chk("lu_stall_off", 32'(bus.stall), 32'd0);
        chk("lu_bubble_a", 32'(bus.fwd_a_sel), 32'd0);
        edge_clk();
        chk("lu_a", 32'(bus.fwd_a_sel), 32'd2);
        chk("lu_b", 32'(bus.fwd_b_sel), 32'd2);
        idle(3);
    endtask

    initial begin
        drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0);
        chk("rst_a", 32'(bus.fwd_a_sel), 32'd0);
        chk("rst_b", 32'(bus.fwd_b_sel), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        edge_clk();
        rst_n = 1'b1;
        idle(2);

        scen_ex_mem();

        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        edge_clk();
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
        edge_clk();
        drive(1'b1, 5'd4, 5'd5, 5'd10, 1'b1, 1'b0, 1'b0);
        edge_clk();
        chk("memwb_b", 32'(bus.fwd_b_sel), 32'd2);
        chk("memwb_a", 32'(bus.fwd_a_sel), 32'd0);
        idle(3);

        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        edge_clk();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        edge_clk();
        drive(1'b1, 5'd5, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
        edge_clk();
        chk("prio_a", 32'(bus.fwd_a_sel), 32'd1);
        chk("prio_b_x0", 32'(bus.fwd_b_sel), 32'd0);
        idle(3);

        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        edge_clk();
        drive(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
        edge_clk();
        drive(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
        edge_clk();
        drive(1'b1, 5'd5, 5'd5, 5'd13, 1'b1, 1'b0, 1'b0);
        edge_clk();
        chk("dist3_a", 32'(bus.fwd_a_sel), 32'd0);
        chk("dist3_b", 32'(bus.fwd_b_sel), 32'd0);
        idle(3);

        scen_load_use();

        drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
        edge_clk();
        drive(1'b0, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("lu_invalid_nostall", 32'(bus.stall), 32'd0);
        idle(3);

        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        edge_clk();
        drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        edge_clk();
        chk("x0_a", 32'(bus.fwd_a_sel), 32'd0);
        idle(3);

        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1);
        edge_clk();
        drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
        edge_clk();
        chk("flush_a", 32'(bus.fwd_a_sel), 32'd0);
        chk("flush_b", 32'(bus.fwd_b_sel), 32'd0);
        idle(3);

        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
        edge_clk();
        drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        edge_clk();
        drive(1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_a", 32'(bus.fwd_a_sel), 32'd1);
        chk("pre_rst_stall", 32'(bus.stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a", 32'(bus.fwd_a_sel), 32'd0);
        chk("mid_rst_b", 32'(bus.fwd_b_sel), 32'd0);
        chk("mid_rst_stall", 32'(bus.stall), 32'd0);
        edge_clk();
        chk("rst_hold_stall", 32'(bus.stall), 32'd0);
        rst_n = 1'b1;
        edge_clk();
        chk("post_rst_a", 32'(bus.fwd_a_sel), 32'd0);
        chk("post_rst_b", 32'(bus.fwd_b_sel), 32'd0);
        idle(3);

`ifdef FWD_PERF_EN
        rst_n = 1'b0;
        #1;
        chk("perf_rst_stall_cnt", stall_cnt, 32'd0);
        chk("perf_rst_fwd_cnt", fwd_cnt, 32'd0);
        rst_n = 1'b1;
        idle(2);
        scen_load_use();
        scen_ex_mem();
        chk("perf_stall_cnt", stall_cnt, 32'd1);
        chk("perf_fwd_cnt", fwd_cnt, 32'd2);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
